// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                flush;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic [DATA_W-1:0]   if_rdata;
  logic                if_ack;
  logic                ls_req;
  logic                ls_we;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_wstrb;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_ack;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;
  logic                stall;
  modport master (
    input  flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rdata, mem_ready,
    output if_rdata, if_ack, ls_rdata, ls_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, stall
  );
  modport slave (
    output flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rdata, mem_ready,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, LS priority with IF anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic              drop_q, drop_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]     mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic              starved, grant_ls, grant_if, ls_store;
  assign starved  = starve_q == SW'(STARVE_MAX);
  assign grant_ls = bus.ls_req & ~(bus.if_req & starved & ~bus.flush);
  assign grant_if = ~grant_ls & bus.if_req & ~bus.flush;
  assign ls_store = grant_ls & bus.ls_we;
  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if (state_q == IDLE && (grant_ls | grant_if)) begin
      state_d     = WAIT;
      owner_ls_d  = grant_ls;
      mem_en_d    = 1'b1;
      mem_we_d    = ls_store;
      mem_addr_d  = grant_ls ? bus.ls_addr : bus.if_addr;
      mem_wdata_d = ls_store ? bus.ls_wdata : '0;
      mem_wstrb_d = ls_store ? bus.ls_wstrb : '0;
      starve_d    = (grant_ls & bus.if_req) ? (starved ? starve_q : starve_q + 1'b1) : '0;
    end else if (state_q == WAIT) begin
      // a flush on the completion edge itself must still suppress the fetch ack
      drop_d = drop_q | (~owner_ls_q & bus.flush);
      if (bus.mem_ready) begin
        state_d    = RESP;
        ls_ack_d   = owner_ls_q;
        if_ack_d   = ~owner_ls_q & ~drop_d;
        ls_rdata_d = owner_ls_q ? bus.mem_rdata : ls_rdata_q;
        if_rdata_d = if_ack_d ? bus.mem_rdata : if_rdata_q;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
      drop_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      {owner_ls_q, drop_q, starve_q, mem_en_q, mem_we_q, mem_addr_q, mem_wdata_q, mem_wstrb_q} <= '0;
      {if_rdata_q, ls_rdata_q, if_ack_q, ls_ack_q} <= '0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
    end
  end
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.stall     = (bus.if_req & ~if_ack_q & ~bus.flush) | (bus.ls_req & ~ls_ack_q);
endmodule
